// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and helpers for the cache set controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WB     = 3'd2,
        FILL   = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Width of a way index; a single-way set still needs a 1-bit index.
    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/plru_tree.sv
// ============================================================================
// Module      : plru_tree
// Description : Heap-indexed tree pseudo-LRU state with touch and victim walk.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module plru_tree
    import cache_pkg::*;
#(
    parameter  int WAYS  = 4,
    localparam int WAY_W = way_width(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             touch_en,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] victim_way
);

    localparam int NODES = WAYS - 1;

    logic [NODES-1:0] r_tree;
    logic [NODES-1:0] w_tree_nxt;
    logic [WAY_W-1:0] w_victim;

    // Root-to-leaf walk; each visited bit supplies the next way-index bit, MSB first.
    always_comb begin
        logic [WAY_W-1:0] node;
        w_victim = '0;
        node     = '0;
        for (int l = 0; l < WAY_W; l++) begin
            w_victim[WAY_W-1-l] = r_tree[node];
            node = (node << 1) + WAY_W'(1) + WAY_W'(r_tree[node]);
        end
    end

    always_comb begin
        logic [WAY_W-1:0] node;
        logic             dir;
        w_tree_nxt = r_tree;
        node       = '0;
        dir        = 1'b0;
        if (touch_en) begin
            for (int l = 0; l < WAY_W; l++) begin
                dir               = touch_way[WAY_W-1-l];
                w_tree_nxt[node]  = ~dir;
                node = (node << 1) + WAY_W'(1) + WAY_W'(dir);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_tree <= '0;
        end else begin
            r_tree <= w_tree_nxt;
        end
    end

    assign victim_way = w_victim;

endmodule

`default_nettype wire

// File: rtl/cache_set_plru.sv
// ============================================================================
// Module      : cache_set_plru
// Description : One N-way cache set: tag match, PLRU victim, writeback/refill FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_set_plru
    import cache_pkg::*;
#(
    parameter  int WAYS  = 4,
    parameter  int TAG_W = 19,
    localparam int WAY_W = way_width(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             req_write,
    input  logic             inv_all,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic             fill_valid,
    input  logic             fill_ready,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [WAY_W-1:0] resp_way,
    output logic [WAYS-1:0]  valid_vec,
    output logic [WAYS-1:0]  dirty_vec
);

    state_t r_state;
    state_t w_state_nxt;

    logic [TAG_W-1:0] r_tag [WAYS];
    logic [WAYS-1:0]  r_valid;
    logic [WAYS-1:0]  r_dirty;
    logic [TAG_W-1:0] r_req_tag;
    logic             r_req_write;
    logic [WAY_W-1:0] r_victim;
    logic             r_resp_hit;
    logic [WAY_W-1:0] r_resp_way;

    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic             w_has_inv;
    logic [WAY_W-1:0] w_inv_way;
    logic [WAY_W-1:0] w_plru_victim;
    logic [WAY_W-1:0] w_miss_way;
    logic             w_accept;
    logic             w_clr;
    logic             w_touch_en;
    logic [WAY_W-1:0] w_touch_way;

    assign req_ready = (r_state == IDLE) && !inv_all;
    assign w_accept  = req_valid && req_ready;
    assign w_clr     = (r_state == IDLE) && inv_all;

    // Scan downward so the lowest matching / invalid index is the one kept.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == r_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
            if (!r_valid[i]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(i);
            end
        end
    end

    assign w_miss_way = w_has_inv ? w_inv_way : w_plru_victim;

    assign w_touch_en  = ((r_state == LOOKUP) && w_hit) ||
                         ((r_state == FILL) && fill_ready);
    assign w_touch_way = (r_state == FILL) ? r_victim : w_hit_way;

    plru_tree #(
        .WAYS (WAYS)
    ) u_plru (
        .clk        (clk),
        .rst        (rst),
        .clr        (w_clr),
        .touch_en   (w_touch_en),
        .touch_way  (w_touch_way),
        .victim_way (w_plru_victim)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (w_hit) begin
                    w_state_nxt = RESP;
                end else if (r_valid[w_miss_way] && r_dirty[w_miss_way]) begin
                    w_state_nxt = WB;
                end else begin
                    w_state_nxt = FILL;
                end
            end
            WB: begin
                if (wb_ready) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (fill_ready) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WAYS; i++) begin
                r_tag[i] <= '0;
            end
            r_valid     <= '0;
            r_dirty     <= '0;
            r_req_tag   <= '0;
            r_req_write <= 1'b0;
            r_victim    <= '0;
            r_resp_hit  <= 1'b0;
            r_resp_way  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Invalidation discards dirty lines; the owner flushes beforehand.
                    if (w_clr) begin
                        r_valid <= '0;
                        r_dirty <= '0;
                    end else if (w_accept) begin
                        r_req_tag   <= req_tag;
                        r_req_write <= req_write;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        if (r_req_write) begin
                            r_dirty[w_hit_way] <= 1'b1;
                        end
                        r_resp_hit <= 1'b1;
                        r_resp_way <= w_hit_way;
                    end else begin
                        r_victim <= w_miss_way;
                    end
                end
                FILL: begin
                    if (fill_ready) begin
                        r_tag[r_victim]   <= r_req_tag;
                        r_valid[r_victim] <= 1'b1;
                        r_dirty[r_victim] <= r_req_write;
                        r_resp_hit        <= 1'b0;
                        r_resp_way        <= r_victim;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wb_valid   = (r_state == WB);
    assign wb_tag     = r_tag[r_victim];
    assign fill_valid = (r_state == FILL);
    assign resp_valid = (r_state == RESP);
    assign resp_hit   = r_resp_hit;
    assign resp_way   = r_resp_way;
    assign valid_vec  = r_valid;
    assign dirty_vec  = r_dirty;

endmodule

`default_nettype wire
